fetch_prefetch: RTL and testbench
=================================

// Module: fetch_prefetch
// PURPOSE
//  Parametrised successor to the single-PC fetch stage: decoupled instruction fetch with a prefetch queue.
//  Issues in-order word reads to IMEM through a valid/ready handshake and buffers {pc, instr} pairs in a DEPTH-entry FIFO.
//  Delivers entries to DECODE through a valid/ready handshake; dec_ready=0 replaces the old stall input.
//  On a branch/jump redirect from EXECUTE it flushes the FIFO and discards any in-flight IMEM responses.
// PARAMETERS
//  BASE_ADDR        32'h80020000  reset PC
//  ADDR_W           32            PC/address width
//  DATA_W           32            instruction width
//  DEPTH            4             FIFO entries; power of two, >=2
//  MAX_OUTSTANDING  2             max IMEM requests in flight; 1..DEPTH
// PORTS
//  clock             in   1       single clock; all state changes on posedge
//  reset             in   1       synchronous, active-high
//  do_branch         in   1       redirect strobe from EXECUTE
//  pc_effective      in   ADDR_W  redirect target; bits [1:0] ignored (treated as 0)
//  imem_req_valid    out  1       read request valid
//  imem_req_ready    in   1       IMEM accepts the request this cycle
//  imem_addr         out  ADDR_W  request address (= fetch PC)
//  imem_access_size  out  2       constant ACCESS_WORD (2'b00)
//  imem_rw           out  1       constant 1 (read)
//  imem_rsp_valid    in   1       in-order response; cannot be back-pressured
//  imem_rsp_data     in   DATA_W  instruction word
//  dec_valid         out  1       FIFO head valid
//  dec_ready         in   1       DECODE accepts the head
//  dec_pc            out  ADDR_W  PC of the head entry
//  dec_instr         out  DATA_W  instruction of the head entry
// BEHAVIOUR
//  Reset: fetch_pc=BASE_ADDR, state=RUN, FIFO empty, outstanding=0; dec_valid=0, imem_req_valid=0.
//  Reset mid-flight: late responses that arrive after reset is released are dropped; response in the reset cycle is ignored.
//  Credit: imem_req_valid = (state==RUN) && !do_branch && (fifo_count+outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
//  Issue: on req_valid && req_ready, outstanding++ and fetch_pc += 4. PC wraps modulo 2^ADDR_W.
//  Response in RUN: push {pc_of_request, rsp_data}. Request PCs are tracked in an in-order tag queue or derived from a pc_tail counter.
//  Credit guarantees that a push never sees a full FIFO.
//  Pop: on dec_valid && dec_ready. dec_valid/dec_pc/dec_instr are registered FIFO head contents (no combinational rsp->dec path).
//  Latency: minimum 1 cycle from rsp_valid to dec_valid.
//  Push and pop in the same cycle are both performed; count is unchanged.
//  FSM, two states:
//    RUN   --do_branch && (outstanding_next>0)--> FLUSH
//    RUN   --do_branch && outstanding_next==0--> RUN  (pc=target)
//    FLUSH: no requests; each rsp_valid decrements outstanding and its data is discarded.
//    FLUSH --outstanding reaches 0--> RUN
//    FLUSH --do_branch--> FLUSH with target updated (last redirect wins).
//  Redirect cycle:
//    fetch_pc <= {pc_effective[ADDR_W-1:2],2'b00}; FIFO cleared next cycle; dec_valid=0 from the next cycle.
//    A dec handshake in the redirect cycle still completes.
//    A response arriving in the redirect cycle is discarded and decrements outstanding.
//    No request is issued in the redirect cycle.
//  outstanding_next accounts for an issue and a response in the same cycle.
// CONFIGURATION
//  FETCH_STATS_EN defined: adds outputs stat_fetched, stat_flushes, stat_stall_cycles (32 bits each, saturating, cleared by reset).
//    stat_fetched counts dec handshakes.
//    stat_flushes counts do_branch pulses.
//    stat_stall_cycles counts cycles with dec_valid && !dec_ready.
//  FETCH_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  mips_pkg (shared): ACCESS_WORD=2'b00, RESET_VECTOR=32'h80020000, fetch_entry_t {pc, instr}, fetch_state_t {RUN, FLUSH}.
//  Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH parameter, push/pop/clear/count/full/empty ports.
//  Top level holds the FSM, PC, outstanding counter, request-PC tracking and the stats counters.
// TESTING
//  1 Reset, dec_ready=1, IMEM always ready, 1-cycle rsp -> dec_pc sequence 80020000, 80020004, 80020008...; instr matches memory.
//  2 dec_ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered, imem_req_valid=0 afterwards.
//    Release -> 4 pops in order with no gap, then fetch resumes.
//  3 2 requests outstanding, do_branch with pc_effective=80020103 -> FLUSH, both responses discarded.
//    Next request is 80020100; first dec_pc after the redirect is 80020100.
//  4 Second do_branch (target 80020200) during FLUSH -> first issued address after FLUSH is 80020200, not the earlier target.
//  5 imem_req_ready=0 for 5 cycles -> imem_addr held stable, fetch_pc not advanced; no request lost or duplicated.
//  6 BASE_ADDR=32'hFFFFFFF8 -> PCs FFFFFFF8, FFFFFFFC, 00000000 (wrap).
//    With FETCH_STATS_EN: after tests 1-3, stat counts equal scoreboard totals.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the MIPS front end.
//   ACCESS_WORD   : IMEM access-size encoding for a 32-bit word read
//   RESET_VECTOR  : default PC after reset
//   fetch_entry_t : one prefetch-queue entry, {pc, instr}
//   fetch_state_t : fetch control states (RUN issues requests, FLUSH drains stale responses)
package mips_pkg;

  localparam logic [1:0]  ACCESS_WORD  = 2'b00;
  localparam logic [31:0] RESET_VECTOR = 32'h8002_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// fetch_fifo
//   Synchronous FIFO holding prefetched {pc, instr} entries.
//   The head entry is read straight out of the storage registers, so the
//   consumer never sees a combinational path from the push side.
// Ports
//   clock, reset : clock and synchronous active-high reset
//   push         : write push_data at the tail (ignored when full)
//   push_data    : entry to write
//   pop          : drop the head entry (ignored when empty)
//   clear        : empty the FIFO at the next edge (dominates push/pop)
//   head         : current head entry
//   count        : number of valid entries
//   full, empty  : occupancy flags
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             clear,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch
//   Decoupled instruction fetch with a prefetch queue. Issues in-order word
//   reads to IMEM, buffers {pc, instr} pairs in a DEPTH-entry FIFO and hands
//   them to DECODE. A redirect flushes the queue and drops every response
//   still in flight before fetching from the new target.
// Ports
//   clock, reset        : clock and synchronous active-high reset
//   do_branch           : redirect strobe from EXECUTE
//   pc_effective        : redirect target (bits [1:0] ignored)
//   imem_req_valid/ready: IMEM request handshake
//   imem_addr           : request address (current fetch PC)
//   imem_access_size    : always ACCESS_WORD
//   imem_rw             : always 1 (read)
//   imem_rsp_valid/data : in-order IMEM response, no back-pressure
//   dec_valid/ready     : DECODE handshake
//   dec_pc, dec_instr   : head entry of the prefetch queue
// Optional feature (macro FETCH_STATS_EN)
//   stat_fetched        : saturating count of DECODE handshakes
//   stat_flushes        : saturating count of do_branch cycles
//   stat_stall_cycles   : saturating count of cycles with dec_valid && !dec_ready
module fetch_prefetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = ADDR_W'(RESET_VECTOR),
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              do_branch,
  input  logic [ADDR_W-1:0] pc_effective,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [1:0]        imem_access_size,
  output logic              imem_rw,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [DATA_W-1:0] dec_instr
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushes,
  output logic [31:0]       stat_stall_cycles
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  outstanding_next;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] rsp_pc;
  logic [SUM_W-1:0]  credit_used;
  logic              issue;
  logic              rsp_take;
  logic              push;
  logic              pop;
  entry_t            push_entry;
  entry_t            head_entry;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^pc_effective[1:0];
  assign branch_target  = {pc_effective[ADDR_W-1:2], 2'b00};

  // Every queued entry plus every in-flight request holds a FIFO slot, so a
  // response can always be pushed.
  assign credit_used    = SUM_W'(fifo_count) + SUM_W'(outstanding);
  assign imem_req_valid = !reset && (state == RUN) && !do_branch &&
                          (credit_used < SUM_W'(DEPTH)) &&
                          (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign issue          = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding belongs to a request issued before
  // reset and is dropped.
  assign rsp_take         = imem_rsp_valid && (outstanding != '0);
  assign outstanding_next = outstanding + OUT_W'(issue) - OUT_W'(rsp_take);

  // Outstanding requests in RUN are contiguous and end at fetch_pc - 4, so the
  // oldest one sits at fetch_pc - 4*outstanding.
  assign rsp_pc           = fetch_pc - ADDR_W'({outstanding, 2'b00});
  assign push             = rsp_take && (state == RUN) && !do_branch && !fifo_full;
  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = imem_rsp_data;
  assign pop              = dec_valid && dec_ready;

  assign imem_addr        = fetch_pc;
  assign imem_access_size = ACCESS_WORD;
  assign imem_rw          = 1'b1;
  assign dec_valid        = !fifo_empty;
  assign dec_pc           = head_entry.pc;
  assign dec_instr        = head_entry.instr;

  // Next-state and next-PC: a redirect always wins over an issue, and the
  // latest redirect target replaces any earlier one.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    if (issue) fetch_pc_next = fetch_pc + ADDR_W'(4);
    case (state)
      RUN:     if (do_branch && (outstanding_next != '0)) state_next = FLUSH;
      FLUSH:   if (outstanding_next == '0) state_next = RUN;
      default: state_next = RUN;
    endcase
    if (do_branch) fetch_pc_next = branch_target;
  end

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= BASE_ADDR;
      outstanding <= '0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (do_branch),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef FETCH_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_fetched      <= '0;
      stat_flushes      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (pop && (stat_fetched != '1))
        stat_fetched <= stat_fetched + 32'd1;
      if (do_branch && (stat_flushes != '1))
        stat_flushes <= stat_flushes + 32'd1;
      if (dec_valid && !dec_ready && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch
//   Directed self-checking bench for fetch_prefetch (default parameters).
//   An in-bench IMEM model answers accepted requests in order one cycle later
//   (or holds them while rsp_hold is set); a monitor records issued addresses
//   and DECODE handshakes. Each test task checks its own scenario.
//   Stats outputs are connected and checked when FETCH_STATS_EN is defined.
module tb_fetch_prefetch;

  logic        clock;
  logic        reset;
  logic        do_branch;
  logic [31:0] pc_effective;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic [1:0]  imem_access_size;
  logic        imem_rw;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushes;
  logic [31:0] stat_stall_cycles;
`endif

  int          n_checks;
  int          n_pass;
  int          nbranch;
  int          stall_cnt;
  logic        rsp_hold;
  logic [31:0] pend[$];
  logic [31:0] issued[$];
  logic [31:0] popped_pc[$];
  logic [31:0] popped_instr[$];

  fetch_prefetch dut (
    .clock            (clock),
    .reset            (reset),
    .do_branch        (do_branch),
    .pc_effective     (pc_effective),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_access_size (imem_access_size),
    .imem_rw          (imem_rw),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .dec_pc           (dec_pc),
    .dec_instr        (dec_instr)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched      (stat_fetched),
    .stat_flushes      (stat_flushes),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // IMEM model and monitor: responses change on the falling edge, the
  // handshakes are observed just before each rising edge.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    stall_cnt      = 0;
    forever begin
      @(negedge clock);
      if (!rsp_hold && pend.size() > 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      #4;
      if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
        pend.push_back(imem_addr);
        issued.push_back(imem_addr);
      end
      if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
        popped_pc.push_back(dec_pc);
        popped_instr.push_back(dec_instr);
      end
      if (dec_valid === 1'b1 && dec_ready === 1'b0) stall_cnt++;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_pops(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (popped_pc.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_issues(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (issued.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (imem_req_valid !== 1'b0) $display("[TB] FAIL reset_req_valid: got %b want 0", imem_req_valid);
    else n_pass++;
    n_checks++;
    if (dec_valid !== 1'b0) $display("[TB] FAIL reset_dec_valid: got %b want 0", dec_valid);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 32'h8002_0000) $display("[TB] FAIL reset_addr: got %h want 80020000", imem_addr);
    else n_pass++;
    n_checks++;
    if (imem_access_size !== 2'b00) $display("[TB] FAIL access_size: got %b want 00", imem_access_size);
    else n_pass++;
    n_checks++;
    if (imem_rw !== 1'b1) $display("[TB] FAIL rw: got %b want 1", imem_rw);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1) $display("[TB] FAIL post_reset_req_valid: got %b want 1", imem_req_valid);
    else n_pass++;
  endtask

  task automatic test_stream();
    bit ok;
    logic [31:0] exp_pc;
    wait_pops(6, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL stream_timeout: got %0d pops want 6", popped_pc.size());
    else n_pass++;
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        exp_pc = 32'h8002_0000 + 32'(4 * i);
        n_checks++;
        if (popped_pc[i] !== exp_pc) $display("[TB] FAIL stream_pc[%0d]: got %h want %h", i, popped_pc[i], exp_pc);
        else n_pass++;
        n_checks++;
        if (popped_instr[i] !== mem_word(exp_pc))
          $display("[TB] FAIL stream_instr[%0d]: got %h want %h", i, popped_instr[i], mem_word(exp_pc));
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int base_pop;
    int iss_rel;
    logic [31:0] exp_pc;
    tick();
    dec_ready = 1'b0;
    base_pop  = popped_pc.size();
    repeat (10) tick();
    n_checks++;
    if (popped_pc.size() != base_pop) $display("[TB] FAIL bp_no_pop: got %0d pops want %0d", popped_pc.size(), base_pop);
    else n_pass++;
    n_checks++;
    if (issued.size() - popped_pc.size() != 4)
      $display("[TB] FAIL bp_buffered: got %0d want 4", issued.size() - popped_pc.size());
    else n_pass++;
    n_checks++;
    if (imem_req_valid !== 1'b0) $display("[TB] FAIL bp_req_valid: got %b want 0", imem_req_valid);
    else n_pass++;
    n_checks++;
    if (dec_valid !== 1'b1) $display("[TB] FAIL bp_dec_valid: got %b want 1", dec_valid);
    else n_pass++;
    exp_pc = 32'h8002_0000 + 32'(4 * base_pop);
    n_checks++;
    if (dec_pc !== exp_pc) $display("[TB] FAIL bp_head_pc: got %h want %h", dec_pc, exp_pc);
    else n_pass++;
    dec_ready = 1'b1;
    iss_rel   = issued.size();
    repeat (4) tick();
    n_checks++;
    if (popped_pc.size() != base_pop + 4)
      $display("[TB] FAIL bp_drain_count: got %0d want %0d", popped_pc.size(), base_pop + 4);
    else n_pass++;
    if (popped_pc.size() >= base_pop + 4) begin
      for (int i = 0; i < 4; i++) begin
        exp_pc = 32'h8002_0000 + 32'(4 * (base_pop + i));
        n_checks++;
        if (popped_pc[base_pop + i] !== exp_pc)
          $display("[TB] FAIL bp_drain_pc[%0d]: got %h want %h", i, popped_pc[base_pop + i], exp_pc);
        else n_pass++;
      end
    end
    n_checks++;
    if (issued.size() <= iss_rel) $display("[TB] FAIL bp_resume: got %0d issues want >%0d", issued.size(), iss_rel);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit ok;
    int iss_base;
    int pop_base;
    tick();
    rsp_hold = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (imem_req_valid !== 1'b0) $display("[TB] FAIL flush_max_outstanding: got %b want 0", imem_req_valid);
    else n_pass++;
    do_branch    = 1'b1;
    pc_effective = 32'h8002_0103;
    nbranch++;
    tick();
    do_branch = 1'b0;
    iss_base  = issued.size();
    pop_base  = popped_pc.size();
    n_checks++;
    if (imem_addr !== 32'h8002_0100) $display("[TB] FAIL flush_target: got %h want 80020100", imem_addr);
    else n_pass++;
    n_checks++;
    if (dec_valid !== 1'b0) $display("[TB] FAIL flush_dec_valid: got %b want 0", dec_valid);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (imem_req_valid !== 1'b0) $display("[TB] FAIL flush_holds_req: got %b want 0", imem_req_valid);
    else n_pass++;
    rsp_hold = 1'b0;
    wait_issues(iss_base + 1, ok);
    n_checks++;
    if (!ok || issued[iss_base] !== 32'h8002_0100)
      $display("[TB] FAIL flush_first_issue: got %h want 80020100", ok ? issued[iss_base] : 32'hx);
    else n_pass++;
    wait_pops(pop_base + 1, ok);
    n_checks++;
    if (!ok || popped_pc[pop_base] !== 32'h8002_0100)
      $display("[TB] FAIL flush_first_dec_pc: got %h want 80020100", ok ? popped_pc[pop_base] : 32'hx);
    else n_pass++;
    n_checks++;
    if (!ok || popped_instr[pop_base] !== mem_word(32'h8002_0100))
      $display("[TB] FAIL flush_first_instr: got %h want %h", ok ? popped_instr[pop_base] : 32'hx,
               mem_word(32'h8002_0100));
    else n_pass++;
  endtask

  task automatic test_double_branch();
    bit ok;
    int iss_base;
    int pop_base;
    tick();
    rsp_hold = 1'b1;
    repeat (5) tick();
    do_branch    = 1'b1;
    pc_effective = 32'h8002_0400;
    nbranch++;
    tick();
    do_branch = 1'b0;
    iss_base  = issued.size();
    pop_base  = popped_pc.size();
    tick();
    n_checks++;
    if (imem_req_valid !== 1'b0) $display("[TB] FAIL dbl_in_flush: got %b want 0", imem_req_valid);
    else n_pass++;
    do_branch    = 1'b1;
    pc_effective = 32'h8002_0202;
    nbranch++;
    tick();
    do_branch = 1'b0;
    n_checks++;
    if (imem_addr !== 32'h8002_0200) $display("[TB] FAIL dbl_target: got %h want 80020200", imem_addr);
    else n_pass++;
    rsp_hold = 1'b0;
    wait_issues(iss_base + 1, ok);
    n_checks++;
    if (!ok || issued[iss_base] !== 32'h8002_0200)
      $display("[TB] FAIL dbl_first_issue: got %h want 80020200", ok ? issued[iss_base] : 32'hx);
    else n_pass++;
    wait_pops(pop_base + 1, ok);
    n_checks++;
    if (!ok || popped_pc[pop_base] !== 32'h8002_0200)
      $display("[TB] FAIL dbl_first_dec_pc: got %h want 80020200", ok ? popped_pc[pop_base] : 32'hx);
    else n_pass++;
  endtask

  task automatic test_req_stall();
    bit ok;
    int iss_base;
    int pop_base;
    logic [31:0] exp_pc;
    tick();
    imem_req_ready = 1'b0;
    do_branch      = 1'b1;
    pc_effective   = 32'h8002_1000;
    nbranch++;
    tick();
    do_branch = 1'b0;
    repeat (3) tick();
    iss_base = issued.size();
    pop_base = popped_pc.size();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (imem_req_valid !== 1'b1) $display("[TB] FAIL stall_req_valid[%0d]: got %b want 1", i, imem_req_valid);
      else n_pass++;
      n_checks++;
      if (imem_addr !== 32'h8002_1000) $display("[TB] FAIL stall_addr[%0d]: got %h want 80021000", i, imem_addr);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (issued.size() != iss_base) $display("[TB] FAIL stall_no_issue: got %0d want %0d", issued.size(), iss_base);
    else n_pass++;
    imem_req_ready = 1'b1;
    wait_pops(pop_base + 3, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL stall_timeout: got %0d pops want %0d", popped_pc.size(), pop_base + 3);
    else n_pass++;
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        exp_pc = 32'h8002_1000 + 32'(4 * i);
        n_checks++;
        if (popped_pc[pop_base + i] !== exp_pc)
          $display("[TB] FAIL stall_dec_pc[%0d]: got %h want %h", i, popped_pc[pop_base + i], exp_pc);
        else n_pass++;
        n_checks++;
        if (issued[iss_base + i] !== exp_pc)
          $display("[TB] FAIL stall_issue[%0d]: got %h want %h", i, issued[iss_base + i], exp_pc);
        else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int pop_base;
    logic [31:0] exp_wrap [4];
    exp_wrap = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    tick();
    do_branch    = 1'b1;
    pc_effective = 32'hFFFF_FFF8;
    nbranch++;
    tick();
    do_branch = 1'b0;
    pop_base  = popped_pc.size();
    wait_pops(pop_base + 4, ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL wrap_timeout: got %0d pops want %0d", popped_pc.size(), pop_base + 4);
    else n_pass++;
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (popped_pc[pop_base + i] !== exp_wrap[i])
          $display("[TB] FAIL wrap_pc[%0d]: got %h want %h", i, popped_pc[pop_base + i], exp_wrap[i]);
        else n_pass++;
      end
    end
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    tick();
    n_checks++;
    if (stat_fetched !== 32'(popped_pc.size()))
      $display("[TB] FAIL stat_fetched: got %0d want %0d", stat_fetched, popped_pc.size());
    else n_pass++;
    n_checks++;
    if (stat_flushes !== 32'(nbranch)) $display("[TB] FAIL stat_flushes: got %0d want %0d", stat_flushes, nbranch);
    else n_pass++;
    n_checks++;
    if (stat_stall_cycles !== 32'(stall_cnt))
      $display("[TB] FAIL stat_stall_cycles: got %0d want %0d", stat_stall_cycles, stall_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    nbranch        = 0;
    rsp_hold       = 1'b0;
    reset          = 1'b1;
    do_branch      = 1'b0;
    pc_effective   = '0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    $display("[TB] start");
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_double_branch();
    test_req_stall();
    test_wrap();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
